// File: rtl/mips_define.sv
// Shared types and constants for the MIPS64 pipeline stall/flush sequencer.
package mips_define;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned REG_W = 5;

    localparam logic [XLEN-1:0] EXC_VECTOR_DEFAULT = 64'h0000_0000_8000_0180;

    typedef enum logic [1:0] {
        RUN           = 2'd0,
        DRAIN         = 2'd1,
        REDIRECT_EXC  = 2'd2,
        REDIRECT_ERET = 2'd3
    } ctrl_state_t;

    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8,
        EXC_BP  = 5'd9,
        EXC_RI  = 5'd10,
        EXC_OV  = 5'd12
    } exc_code_t;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_EXC = 2'd1,
        PC_EPC = 2'd2
    } pc_sel_t;

    // Winning exception/ERET request for the current cycle
    typedef struct packed {
        logic            take;
        logic            eret;
        logic            ovf;
        exc_code_t       code;
        logic [XLEN-1:0] epc;
    } exc_req_t;

endpackage

// File: rtl/mips_pipeline_ctrl_if.sv
// Status inputs from ID/EX/MEM/CP0 and stall/flush/redirect controls back to the pipeline.
interface mips_pipeline_ctrl_if;

    logic                                 id_valid;
    logic [mips_define::XLEN-1:0]         id_pc;
    logic [mips_define::REG_W-1:0]        id_rs;
    logic [mips_define::REG_W-1:0]        id_rt;
    logic                                 id_uses_rs;
    logic                                 id_B_is_reg;
    logic                                 id_jr;
    logic                                 id_except;
    logic                                 id_syscall;
    logic                                 id_break;
    logic                                 id_eret;
    logic                                 ex_valid;
    logic [mips_define::XLEN-1:0]         ex_pc;
    logic                                 ex_mem_read;
    logic                                 ex_we;
    logic [mips_define::REG_W-1:0]        ex_rd;
    logic                                 ex_overflow;
    logic                                 mem_mem_read;
    logic [mips_define::REG_W-1:0]        mem_rd;
    logic                                 mem_busy;
    logic                                 irq;
    logic                                 cp0_ie;
    logic                                 cp0_exl;
    logic [mips_define::XLEN-1:0]         cp0_epc;

    logic                                 pc_stall;
    logic                                 if_id_stall;
    logic                                 id_ex_stall;
    logic                                 ex_mem_stall;
    logic                                 mem_wb_stall;
    logic                                 if_id_flush;
    logic                                 id_ex_flush;
    logic                                 ex_mem_flush;
    logic [1:0]                           pc_sel;
    logic [mips_define::XLEN-1:0]         redirect_pc;
    logic                                 exc_commit;
    logic [4:0]                           exc_code;
    logic [mips_define::XLEN-1:0]         epc_out;
    logic                                 eret_commit;

    modport master (
        input  id_valid, id_pc, id_rs, id_rt, id_uses_rs, id_B_is_reg, id_jr,
               id_except, id_syscall, id_break, id_eret,
               ex_valid, ex_pc, ex_mem_read, ex_we, ex_rd, ex_overflow,
               mem_mem_read, mem_rd, mem_busy, irq, cp0_ie, cp0_exl, cp0_epc,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
               if_id_flush, id_ex_flush, ex_mem_flush, pc_sel, redirect_pc,
               exc_commit, exc_code, epc_out, eret_commit
    );

    modport slave (
        output id_valid, id_pc, id_rs, id_rt, id_uses_rs, id_B_is_reg, id_jr,
               id_except, id_syscall, id_break, id_eret,
               ex_valid, ex_pc, ex_mem_read, ex_we, ex_rd, ex_overflow,
               mem_mem_read, mem_rd, mem_busy, irq, cp0_ie, cp0_exl, cp0_epc,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
               if_id_flush, id_ex_flush, ex_mem_flush, pc_sel, redirect_pc,
               exc_commit, exc_code, epc_out, eret_commit
    );

endinterface

// File: rtl/mips_hazard_detect.sv
// Combinational load-use and ID-resolved-jump hazard detection.
module mips_hazard_detect
    import mips_define::*;
(
    input  logic             id_uses_rs,
    input  logic             id_B_is_reg,
    input  logic             id_jr,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_mem_read,
    input  logic             ex_we,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    output logic             bubble_c
);

    logic load_use_c;
    logic jump_c;

    // Load in EX whose result an ID source operand needs next cycle
    always_comb begin
        load_use_c = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs && (ex_rd == id_rs)) || (id_B_is_reg && (ex_rd == id_rt)));
    end

    // jr/jalr reads rs in ID, so any in-flight producer of rs must land first
    always_comb begin
        jump_c = id_jr && (id_rs != '0) &&
                 ((ex_we && (ex_rd == id_rs)) || (mem_mem_read && (mem_rd == id_rs)));
    end

    // Either hazard inserts the same one-cycle bubble
    always_comb begin
        bubble_c = load_use_c || jump_c;
    end

endmodule

// File: rtl/mips_pipeline_ctrl.sv
// Pipeline stall/flush sequencer: hazard bubbles, memory freeze, precise exceptions and ERET.
module mips_pipeline_ctrl
    import mips_define::*;
#(
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_pipeline_ctrl_if.master bus
);

    ctrl_state_t     state;
    ctrl_state_t     state_next;
    exc_code_t       code_q;
    exc_code_t       code_d;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] epc_d;
    logic            kind_eret_q;
    logic            kind_eret_d;
    exc_req_t        req;
    logic            bubble_c;

    mips_hazard_detect u_hazard (
        .id_uses_rs   (bus.id_uses_rs),
        .id_B_is_reg  (bus.id_B_is_reg),
        .id_jr        (bus.id_jr),
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .ex_mem_read  (bus.ex_mem_read),
        .ex_we        (bus.ex_we),
        .ex_rd        (bus.ex_rd),
        .mem_mem_read (bus.mem_mem_read),
        .mem_rd       (bus.mem_rd),
        .bubble_c     (bubble_c)
    );

    // Oldest-first selection: EX overflow beats every ID-stage cause
    always_comb begin
        req = '0;
        if (bus.ex_valid && bus.ex_overflow) begin
            req.take = 1'b1;
            req.ovf  = 1'b1;
            req.code = EXC_OV;
            req.epc  = bus.ex_pc;
        end else if (bus.id_valid && bus.id_except) begin
            req.take = 1'b1;
            req.code = EXC_RI;
            req.epc  = bus.id_pc;
        end else if (bus.id_valid && bus.id_syscall) begin
            req.take = 1'b1;
            req.code = EXC_SYS;
            req.epc  = bus.id_pc;
        end else if (bus.id_valid && bus.id_break) begin
            req.take = 1'b1;
            req.code = EXC_BP;
            req.epc  = bus.id_pc;
        end else if (bus.irq && bus.cp0_ie && !bus.cp0_exl && bus.id_valid) begin
            req.take = 1'b1;
            req.code = EXC_INT;
            req.epc  = bus.id_pc;
        end else if (bus.id_valid && bus.id_eret) begin
            req.eret = 1'b1;
        end
    end

    // Next state and stage controls; everything stays quiet while reset is held
    always_comb begin
        state_next       = state;
        code_d           = code_q;
        epc_d            = epc_q;
        kind_eret_d      = kind_eret_q;
        bus.pc_stall     = 1'b0;
        bus.if_id_stall  = 1'b0;
        bus.id_ex_stall  = 1'b0;
        bus.ex_mem_stall = 1'b0;
        bus.mem_wb_stall = 1'b0;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_flush = 1'b0;
        bus.pc_sel       = PC_SEQ;
        bus.redirect_pc  = '0;
        bus.exc_commit   = 1'b0;
        bus.eret_commit  = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (req.take || req.eret) begin
                        kind_eret_d = req.eret;
                        if (req.take) begin
                            code_d = req.code;
                            epc_d  = req.epc;
                        end
                        bus.pc_stall     = 1'b1;
                        bus.if_id_flush  = 1'b1;
                        bus.id_ex_flush  = 1'b1;
                        bus.ex_mem_flush = req.ovf;
                        state_next       = DRAIN;
                    end else if (bus.mem_busy) begin
                        bus.pc_stall     = 1'b1;
                        bus.if_id_stall  = 1'b1;
                        bus.id_ex_stall  = 1'b1;
                        bus.ex_mem_stall = 1'b1;
                        bus.mem_wb_stall = 1'b1;
                    end else if (bubble_c) begin
                        bus.pc_stall    = 1'b1;
                        bus.if_id_stall = 1'b1;
                        bus.id_ex_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    bus.pc_stall    = 1'b1;
                    bus.if_id_flush = 1'b1;
                    bus.id_ex_flush = 1'b1;
                    if (!bus.mem_busy) begin
                        state_next = kind_eret_q ? REDIRECT_ERET : REDIRECT_EXC;
                    end
                end
                REDIRECT_EXC: begin
                    bus.pc_sel      = PC_EXC;
                    bus.redirect_pc = EXC_VECTOR;
                    bus.exc_commit  = 1'b1;
                    bus.if_id_flush = 1'b1;
                    state_next      = RUN;
                end
                REDIRECT_ERET: begin
                    bus.pc_sel      = PC_EPC;
                    bus.redirect_pc = bus.cp0_epc;
                    bus.eret_commit = 1'b1;
                    bus.if_id_flush = 1'b1;
                    state_next      = RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // State plus latched cause/EPC/kind, synchronously cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            code_q      <= EXC_INT;
            epc_q       <= '0;
            kind_eret_q <= 1'b0;
        end else begin
            state       <= state_next;
            code_q      <= code_d;
            epc_q       <= epc_d;
            kind_eret_q <= kind_eret_d;
        end
    end

    assign bus.exc_code = code_q;
    assign bus.epc_out  = epc_q;

endmodule

// File: tb/tb_mips_pipeline_ctrl.sv
// Self-checking bench for mips_pipeline_ctrl: vector table, directed sequences, random vs model.
module tb_mips_pipeline_ctrl;
    import mips_define::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_pipeline_ctrl_if bus();

    mips_pipeline_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          rst_n;
        bit          id_valid;
        logic [63:0] id_pc;
        logic [4:0]  id_rs;
        logic [4:0]  id_rt;
        bit          uses_rs, b_is_reg, jr, except, syscall, brk, eret;
        bit          ex_valid;
        logic [63:0] ex_pc;
        bit          ex_mem_read, ex_we;
        logic [4:0]  ex_rd;
        bit          ex_overflow;
        bit          mem_mem_read;
        logic [4:0]  mem_rd;
        bit          mem_busy;
        bit          irq, ie, exl;
        logic [63:0] cp0_epc;
    } in_t;

    typedef struct packed {
        logic [4:0]  stall;   // pc, if_id, id_ex, ex_mem, mem_wb
        logic [2:0]  flush;   // if_id, id_ex, ex_mem
        logic [1:0]  pc_sel;
        logic [63:0] redirect_pc;
        logic        exc_commit;
        logic        eret_commit;
        logic [4:0]  exc_code;
        logic [63:0] epc_out;
    } out_t;

    typedef struct {
        string      name;
        logic [4:0] ex_rd, id_rs, id_rt, mem_rd;
        bit         ex_mem_read, ex_we, mem_mem_read, uses_rs, b_is_reg, jr, mem_busy;
        logic [4:0] stall;
        logic [2:0] flush;
    } vec_t;

    int n_cmp;
    int n_bad;

    // Reference model: 0 = normal flow, 1 = waiting for memory, 2 = redirect cycle
    int          m_phase;
    bit          m_eret;
    logic [4:0]  m_code;
    logic [63:0] m_epc;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v = '{default: '0};
        v.rst_n = 1'b1;
        return v;
    endfunction

    function automatic bit hazard(input in_t v);
        bit lu, jh;
        lu = v.ex_mem_read && v.ex_rd != 0 &&
             ((v.uses_rs && v.ex_rd == v.id_rs) || (v.b_is_reg && v.ex_rd == v.id_rt));
        jh = v.jr && v.id_rs != 0 &&
             ((v.ex_we && v.ex_rd == v.id_rs) || (v.mem_mem_read && v.mem_rd == v.id_rs));
        return lu || jh;
    endfunction

    // Priority table, oldest first; index 5 is ERET, -1 is nothing
    function automatic int pick(input in_t v);
        bit cond[6];
        int hit;
        cond[0] = v.ex_valid && v.ex_overflow;
        cond[1] = v.id_valid && v.except;
        cond[2] = v.id_valid && v.syscall;
        cond[3] = v.id_valid && v.brk;
        cond[4] = v.irq && v.ie && !v.exl && v.id_valid;
        cond[5] = v.id_valid && v.eret;
        hit = -1;
        for (int i = 5; i >= 0; i--) if (cond[i]) hit = i;
        return hit;
    endfunction

    function automatic logic [4:0] code_of(input int hit);
        logic [4:0] codes [5];
        codes[0] = 5'd12; codes[1] = 5'd10; codes[2] = 5'd8; codes[3] = 5'd9; codes[4] = 5'd0;
        return codes[hit];
    endfunction

    function automatic out_t model_out(input in_t v);
        out_t o;
        int   hit;
        o = '0;
        o.exc_code = m_code;
        o.epc_out  = m_epc;
        if (v.rst_n) begin
            if (m_phase == 0) begin
                hit = pick(v);
                if (hit >= 0) begin
                    o.stall = 5'b10000;
                    o.flush = {2'b11, hit == 0};
                end else if (v.mem_busy) begin
                    o.stall = 5'b11111;
                end else if (hazard(v)) begin
                    o.stall = 5'b11000;
                    o.flush = 3'b010;
                end
            end else if (m_phase == 1) begin
                o.stall = 5'b10000;
                o.flush = 3'b110;
            end else begin
                o.flush = 3'b100;
                if (m_eret) begin
                    o.pc_sel      = 2'd2;
                    o.redirect_pc = v.cp0_epc;
                    o.eret_commit = 1'b1;
                end else begin
                    o.pc_sel      = 2'd1;
                    o.redirect_pc = 64'h8000_0180;
                    o.exc_commit  = 1'b1;
                end
            end
        end
        return o;
    endfunction

    task automatic model_step(input in_t v);
        int hit;
        if (!v.rst_n) begin
            m_phase = 0; m_eret = 1'b0; m_code = '0; m_epc = '0;
        end else if (m_phase == 0) begin
            hit = pick(v);
            if (hit >= 0) begin
                m_phase = 1;
                m_eret  = (hit == 5);
                if (hit < 5) begin
                    m_code = code_of(hit);
                    m_epc  = (hit == 0) ? v.ex_pc : v.id_pc;
                end
            end
        end else if (m_phase == 1) begin
            if (!v.mem_busy) m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic drive(input in_t v);
        rst_n            = v.rst_n;
        bus.id_valid     = v.id_valid;
        bus.id_pc        = v.id_pc;
        bus.id_rs        = v.id_rs;
        bus.id_rt        = v.id_rt;
        bus.id_uses_rs   = v.uses_rs;
        bus.id_B_is_reg  = v.b_is_reg;
        bus.id_jr        = v.jr;
        bus.id_except    = v.except;
        bus.id_syscall   = v.syscall;
        bus.id_break     = v.brk;
        bus.id_eret      = v.eret;
        bus.ex_valid     = v.ex_valid;
        bus.ex_pc        = v.ex_pc;
        bus.ex_mem_read  = v.ex_mem_read;
        bus.ex_we        = v.ex_we;
        bus.ex_rd        = v.ex_rd;
        bus.ex_overflow  = v.ex_overflow;
        bus.mem_mem_read = v.mem_mem_read;
        bus.mem_rd       = v.mem_rd;
        bus.mem_busy     = v.mem_busy;
        bus.irq          = v.irq;
        bus.cp0_ie       = v.ie;
        bus.cp0_exl      = v.exl;
        bus.cp0_epc      = v.cp0_epc;
    endtask

    function automatic out_t sample();
        out_t o;
        o.stall       = {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall, bus.mem_wb_stall};
        o.flush       = {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
        o.pc_sel      = bus.pc_sel;
        o.redirect_pc = bus.redirect_pc;
        o.exc_commit  = bus.exc_commit;
        o.eret_commit = bus.eret_commit;
        o.exc_code    = bus.exc_code;
        o.epc_out     = bus.epc_out;
        return o;
    endfunction

    // One clock: drive, compare against the model mid-cycle, advance the model at the edge
    task automatic cycle(input in_t v, input string name, output out_t a);
        out_t e;
        drive(v);
        @(negedge clk);
        e = model_out(v);
        a = sample();
        check(name, 160'(a), 160'(e));
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    initial begin
        in_t  v;
        out_t a;
        vec_t tab [12];
        n_cmp = 0;
        n_bad = 0;
        m_phase = 0; m_eret = 1'b0; m_code = '0; m_epc = '0;

        //            name          ex_rd  id_rs  id_rt  mem_rd ldEX  exwe  ldMEM uses  Breg  jr    busy  stall      flush
        tab[0]  = '{"lu_rs",       5'd5,  5'd5,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, 3'b010};
        tab[1]  = '{"lu_rd0",      5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b000};
        tab[2]  = '{"lu_rt",       5'd7,  5'd1,  5'd7,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11000, 3'b010};
        tab[3]  = '{"lu_rt_imm",   5'd7,  5'd1,  5'd7,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000};
        tab[4]  = '{"lu_rs_unused",5'd5,  5'd5,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000};
        tab[5]  = '{"jr_ex",       5'd9,  5'd9,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11000, 3'b010};
        tab[6]  = '{"jr_mem_load", 5'd0,  5'd3,  5'd0,  5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11000, 3'b010};
        tab[7]  = '{"jr_rs0",      5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b000};
        tab[8]  = '{"jr_no_we",    5'd9,  5'd9,  5'd0,  5'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b000};
        tab[9]  = '{"busy_hazard", 5'd5,  5'd5,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11111, 3'b000};
        tab[10] = '{"busy_alone",  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 3'b000};
        tab[11] = '{"quiet",       5'd2,  5'd3,  5'd4,  5'd5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 3'b000};

        // Initial reset edge, then reset state
        v = idle();
        v.rst_n = 1'b0;
        drive(v);
        @(posedge clk);
        #1;
        v = idle();
        cycle(v, "reset_state", a);
        check("reset_all_zero", 160'(a), 160'(0));

        // Single-cycle RUN vectors
        for (int i = 0; i < 12; i++) begin
            v = idle();
            v.id_valid = 1'b1;
            v.ex_valid = 1'b1;
            v.ex_rd = tab[i].ex_rd; v.id_rs = tab[i].id_rs; v.id_rt = tab[i].id_rt; v.mem_rd = tab[i].mem_rd;
            v.ex_mem_read = tab[i].ex_mem_read; v.ex_we = tab[i].ex_we; v.mem_mem_read = tab[i].mem_mem_read;
            v.uses_rs = tab[i].uses_rs; v.b_is_reg = tab[i].b_is_reg; v.jr = tab[i].jr; v.mem_busy = tab[i].mem_busy;
            cycle(v, tab[i].name, a);
            check({tab[i].name, "_stall"}, 160'(a.stall), 160'(tab[i].stall));
            check({tab[i].name, "_flush"}, 160'(a.flush), 160'(tab[i].flush));
        end

        // Load-use bubble lasts one cycle: the load has moved to MEM afterwards
        v = idle(); v.id_valid = 1'b1; v.uses_rs = 1'b1; v.id_rs = 5'd5;
        v.ex_mem_read = 1'b1; v.ex_we = 1'b1; v.ex_rd = 5'd5;
        cycle(v, "lu_bubble", a);
        check("lu_bubble_stall", 160'(a.stall), 160'(5'b11000));
        v.ex_mem_read = 1'b0; v.ex_we = 1'b0; v.ex_rd = 5'd0; v.mem_mem_read = 1'b1; v.mem_rd = 5'd5;
        cycle(v, "lu_released", a);
        check("lu_released_stall", 160'(a.stall), 160'(0));

        // Syscall with memory idle: one DRAIN cycle, then redirect to the vector
        v = idle(); v.id_valid = 1'b1; v.syscall = 1'b1; v.id_pc = 64'h400;
        v.ex_mem_read = 1'b1; v.ex_rd = 5'd1; v.uses_rs = 1'b1; v.id_rs = 5'd1;
        cycle(v, "sys_detect", a);
        check("sys_detect_stall", 160'(a.stall), 160'(5'b10000));
        check("sys_detect_flush", 160'(a.flush), 160'(3'b110));
        v = idle();
        cycle(v, "sys_drain", a);
        check("sys_drain_pcsel", 160'(a.pc_sel), 160'(0));
        check("sys_drain_commit", 160'(a.exc_commit), 160'(0));
        cycle(v, "sys_redirect", a);
        check("sys_redir_pcsel", 160'(a.pc_sel), 160'(1));
        check("sys_redir_pc", 160'(a.redirect_pc), 160'(64'h8000_0180));
        check("sys_redir_commit", 160'(a.exc_commit), 160'(1));
        check("sys_redir_code", 160'(a.exc_code), 160'(8));
        check("sys_redir_epc", 160'(a.epc_out), 160'(64'h400));
        check("sys_redir_flush", 160'(a.flush), 160'(3'b100));
        cycle(v, "sys_back_run", a);
        check("sys_back_commit", 160'(a.exc_commit), 160'(0));
        check("sys_back_pcsel", 160'(a.pc_sel), 160'(0));

        // Overflow in EX outranks break in ID
        v = idle(); v.ex_valid = 1'b1; v.ex_overflow = 1'b1; v.ex_pc = 64'h200;
        v.id_valid = 1'b1; v.brk = 1'b1; v.id_pc = 64'h204;
        cycle(v, "ovf_detect", a);
        check("ovf_detect_flush", 160'(a.flush), 160'(3'b111));
        v = idle();
        cycle(v, "ovf_drain", a);
        check("ovf_code", 160'(a.exc_code), 160'(12));
        check("ovf_epc", 160'(a.epc_out), 160'(64'h200));
        cycle(v, "ovf_redirect", a);
        check("ovf_redir_commit", 160'(a.exc_commit), 160'(1));
        cycle(v, "ovf_back_run", a);

        // Interrupt with memory busy for three DRAIN cycles
        v = idle(); v.irq = 1'b1; v.ie = 1'b1; v.id_valid = 1'b1; v.id_pc = 64'h500;
        cycle(v, "irq_detect", a);
        check("irq_detect_stall", 160'(a.stall), 160'(5'b10000));
        v.mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(v, "irq_drain_busy", a);
            check("irq_busy_commit", 160'(a.exc_commit), 160'(0));
            check("irq_busy_stall", 160'(a.stall), 160'(5'b10000));
        end
        v.mem_busy = 1'b0;
        cycle(v, "irq_drain_free", a);
        check("irq_free_commit", 160'(a.exc_commit), 160'(0));
        v.exl = 1'b1;
        cycle(v, "irq_redirect", a);
        check("irq_redir_commit", 160'(a.exc_commit), 160'(1));
        check("irq_redir_code", 160'(a.exc_code), 160'(0));
        check("irq_redir_epc", 160'(a.epc_out), 160'(64'h500));
        cycle(v, "irq_masked_exl", a);
        check("irq_exl_stall", 160'(a.stall), 160'(0));
        cycle(v, "irq_masked_exl2", a);
        check("irq_exl_pcsel", 160'(a.pc_sel), 160'(0));

        // ERET returns to cp0_epc
        v = idle(); v.id_valid = 1'b1; v.eret = 1'b1; v.cp0_epc = 64'h1000;
        cycle(v, "eret_detect", a);
        v = idle(); v.cp0_epc = 64'h1000;
        cycle(v, "eret_drain", a);
        cycle(v, "eret_redirect", a);
        check("eret_pcsel", 160'(a.pc_sel), 160'(2));
        check("eret_pc", 160'(a.redirect_pc), 160'(64'h1000));
        check("eret_commit", 160'(a.eret_commit), 160'(1));
        check("eret_no_exc", 160'(a.exc_commit), 160'(0));
        cycle(v, "eret_back_run", a);
        check("eret_commit_once", 160'(a.eret_commit), 160'(0));

        // Reset during DRAIN clears everything and no commit follows
        v = idle(); v.id_valid = 1'b1; v.syscall = 1'b1; v.id_pc = 64'h700;
        cycle(v, "rst_detect", a);
        v = idle(); v.rst_n = 1'b0;
        cycle(v, "rst_in_drain", a);
        check("rst_drain_stall", 160'(a.stall), 160'(0));
        v = idle();
        for (int k = 0; k < 3; k++) begin
            cycle(v, "rst_after", a);
            check("rst_after_zero", 160'(a), 160'(0));
        end

        // Reset landing on the redirect cycle suppresses the strobe
        v = idle(); v.id_valid = 1'b1; v.brk = 1'b1; v.id_pc = 64'h800;
        cycle(v, "rst2_detect", a);
        v = idle();
        cycle(v, "rst2_drain", a);
        v.rst_n = 1'b0;
        cycle(v, "rst2_redirect", a);
        check("rst2_no_commit", 160'(a.exc_commit), 160'(0));
        v = idle();
        cycle(v, "rst2_after", a);
        check("rst2_after_zero", 160'(a), 160'(0));

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            v = idle();
            v.rst_n        = ($urandom_range(0, 99) != 0);
            v.id_valid     = ($urandom_range(0, 3) != 0);
            v.id_pc        = {32'h0, $urandom};
            v.id_rs        = 5'($urandom_range(0, 3));
            v.id_rt        = 5'($urandom_range(0, 3));
            v.uses_rs      = $urandom_range(0, 1) != 0;
            v.b_is_reg     = $urandom_range(0, 1) != 0;
            v.jr           = ($urandom_range(0, 3) == 0);
            v.except       = ($urandom_range(0, 31) == 0);
            v.syscall      = ($urandom_range(0, 31) == 0);
            v.brk          = ($urandom_range(0, 31) == 0);
            v.eret         = ($urandom_range(0, 23) == 0);
            v.ex_valid     = $urandom_range(0, 1) != 0;
            v.ex_pc        = {32'h0, $urandom};
            v.ex_mem_read  = $urandom_range(0, 1) != 0;
            v.ex_we        = $urandom_range(0, 1) != 0;
            v.ex_rd        = 5'($urandom_range(0, 3));
            v.ex_overflow  = ($urandom_range(0, 23) == 0);
            v.mem_mem_read = $urandom_range(0, 1) != 0;
            v.mem_rd       = 5'($urandom_range(0, 3));
            v.mem_busy     = ($urandom_range(0, 3) == 0);
            v.irq          = ($urandom_range(0, 7) == 0);
            v.ie           = $urandom_range(0, 1) != 0;
            v.exl          = $urandom_range(0, 1) != 0;
            v.cp0_epc      = {32'h0, $urandom};
            cycle(v, "random", a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
